// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard/forwarding unit.
// Forward-select encoding and register-match helper.
package hazard_pkg;

  localparam int AW_DEFAULT = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10,
    FWD_MC = 2'b11
  } fwd_sel_e;

  // x0 never matches: it is hard-wired zero.
  function automatic logic reg_match(
    input logic [31:0] a,
    input logic [31:0] b
  );
    return (a == b) && (a != '0);
  endfunction

endpackage

// File: rtl/mc_scoreboard.sv
// Pending-write scoreboard for the out-of-band multi-cycle unit.
// Tracks per-register pending bits, outstanding count and a done error.
module mc_scoreboard
  import hazard_pkg::*;
#(
  parameter int AW      = AW_DEFAULT,
  parameter int MAX_OUT = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           issue,
  input  logic [AW-1:0]                  issue_rd,
  input  logic                           done,
  input  logic [AW-1:0]                  done_rd,
  output logic [2**AW-1:0]               pending,
  output logic [$clog2(MAX_OUT+1)-1:0]   count,
  output logic                           err
);

  localparam int NREG = 2**AW;
  localparam int CW   = $clog2(MAX_OUT + 1);

  logic [NREG-1:0] pend_q, pend_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_d;
  logic            dec;

  assign dec = done && (cnt_q != '0);

  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    err_d  = 1'b0;
    if (done) begin
      pend_d[done_rd] = 1'b0;
      err_d = (cnt_q == '0) ||
              ((done_rd != '0) && !pend_q[done_rd]);
    end
    // set after clear so a same-cycle reissue keeps the bit
    if (issue && (issue_rd != '0)) begin
      pend_d[issue_rd] = 1'b1;
    end
    if (issue && !dec) begin
      if (cnt_q != CW'(MAX_OUT)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (!issue && dec) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= '0;
      cnt_q  <= '0;
      err    <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      err    <= err_d;
    end
  end

  assign pending = pend_q;
  assign count   = cnt_q;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard, forwarding and multi-cycle scoreboard unit for the 5-stage pipe.
// Drives F/D/E enables and clears plus the E-stage operand selects.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int AW      = AW_DEFAULT,
  parameter int NSRC    = 2,
  parameter int MAX_OUT = 2,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NSRC*AW-1:0]   RsD,
  input  logic [AW-1:0]        RdD,
  input  logic                 McOpD,
  input  logic [NSRC*AW-1:0]   RsE,
  input  logic [AW-1:0]        RdE,
  input  logic [AW-1:0]        RdM,
  input  logic [AW-1:0]        RdW,
  input  logic                 RegWriteM,
  input  logic                 RegWriteW,
  input  logic                 MemReadE,
  input  logic                 McIssueE,
  input  logic                 McDone,
  input  logic [AW-1:0]        McRd,
  input  logic                 PCSrcE,
  output logic [NSRC*2-1:0]    ForwardE,
  output logic                 StallF,
  output logic                 StallD,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic [2**AW-1:0]     McPending,
  output logic                 McBusy,
  output logic                 McErr,
  output logic [CNT_W-1:0]     StallCnt
);

  localparam int CW = $clog2(MAX_OUT + 1);

  logic [CW-1:0] mc_count;
  logic          lus, raw, waw, str, stall;
  logic [31:0]   proj_up;

  mc_scoreboard #(
    .AW      (AW),
    .MAX_OUT (MAX_OUT)
  ) u_sb (
    .clk      (clk),
    .reset_n  (reset_n),
    .issue    (McIssueE),
    .issue_rd (RdE),
    .done     (McDone),
    .done_rd  (McRd),
    .pending  (McPending),
    .count    (mc_count),
    .err      (McErr)
  );

  always_comb begin
    ForwardE = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (RegWriteM &&
          reg_match(32'(RdM), 32'(RsE[i*AW +: AW])))
        ForwardE[i*2 +: 2] = FWD_M;
      else if (RegWriteW &&
          reg_match(32'(RdW), 32'(RsE[i*AW +: AW])))
        ForwardE[i*2 +: 2] = FWD_W;
      else if (McDone &&
          reg_match(32'(McRd), 32'(RsE[i*AW +: AW])))
        ForwardE[i*2 +: 2] = FWD_MC;
      else
        ForwardE[i*2 +: 2] = FWD_RF;
    end
  end

  // a register retiring this cycle is read write-first, so no stall
  always_comb begin
    lus = 1'b0;
    raw = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if ((MemReadE || McIssueE) &&
          reg_match(32'(RdE), 32'(RsD[i*AW +: AW])))
        lus = 1'b1;
      if ((RsD[i*AW +: AW] != '0) &&
          McPending[RsD[i*AW +: AW]] &&
          !(McDone && (McRd == RsD[i*AW +: AW])))
        raw = 1'b1;
    end
    waw = (RdD != '0) && McPending[RdD] &&
          !(McDone && (McRd == RdD));
  end

  assign proj_up = 32'(mc_count) + 32'(McIssueE);
  assign str     = McOpD &&
                   (proj_up >= 32'(MAX_OUT) + 32'(McDone));

  assign stall  = lus || raw || waw || str;
  assign StallF = stall && !PCSrcE;
  assign StallD = stall && !PCSrcE;
  assign FlushD = PCSrcE;
  assign FlushE = PCSrcE || stall;
  assign McBusy = (mc_count == CW'(MAX_OUT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      StallCnt <= '0;
    end else if (StallD && (StallCnt != '1)) begin
      StallCnt <= StallCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Randomized + directed bench for hazard_scoreboard_unit.
// Expected outputs are queued per cycle and checked by a negedge monitor.
module tb_hazard_scoreboard_unit;

  localparam int AW      = 5;
  localparam int NSRC    = 2;
  localparam int MAX_OUT = 2;
  localparam int CNT_W   = 4;
  localparam int SCMAX   = (1 << CNT_W) - 1;

  logic               clk;
  logic               reset_n;
  logic [NSRC*AW-1:0] RsD, RsE;
  logic [AW-1:0]      RdD, RdE, RdM, RdW, McRd;
  logic               McOpD, RegWriteM, RegWriteW;
  logic               MemReadE, McIssueE, McDone, PCSrcE;
  logic [NSRC*2-1:0]  ForwardE;
  logic               StallF, StallD, FlushD, FlushE;
  logic [31:0]        McPending;
  logic               McBusy, McErr;
  logic [CNT_W-1:0]   StallCnt;

  hazard_scoreboard_unit #(
    .AW(AW), .NSRC(NSRC), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .RsD(RsD), .RdD(RdD), .McOpD(McOpD),
    .RsE(RsE), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemReadE(MemReadE), .McIssueE(McIssueE),
    .McDone(McDone), .McRd(McRd), .PCSrcE(PCSrcE),
    .ForwardE(ForwardE), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE),
    .McPending(McPending), .McBusy(McBusy), .McErr(McErr),
    .StallCnt(StallCnt)
  );

  typedef struct {
    logic [NSRC*2-1:0] fwd;
    logic              stf, std, fld, fle;
    logic [31:0]       pend;
    logic              busy, err;
    logic [CNT_W-1:0]  sc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // reference state
  bit [31:0] m_pend;
  int        m_cnt;
  bit        m_err;
  int        m_sc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rs(input logic [NSRC*AW-1:0] v, input int i);
    return int'(v[i*AW +: AW]);
  endfunction

  function automatic void model_clear();
    m_pend = '0;
    m_cnt  = 0;
    m_err  = 1'b0;
    m_sc   = 0;
  endfunction

  function automatic bit hits(input int r);
    return McDone && (int'(McRd) == r);
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    bit lus, raw, waw, str, stall;
    int s;
    e.fwd = '0;
    lus = 0; raw = 0; waw = 0;
    for (int i = 0; i < NSRC; i++) begin
      s = rs(RsE, i);
      if (s != 0) begin
        if (RegWriteM && int'(RdM) == s)      e.fwd[i*2 +: 2] = 2'b10;
        else if (RegWriteW && int'(RdW) == s) e.fwd[i*2 +: 2] = 2'b01;
        else if (hits(s))                     e.fwd[i*2 +: 2] = 2'b11;
      end
      s = rs(RsD, i);
      if ((MemReadE || McIssueE) && RdE != 0 && int'(RdE) == s) lus = 1;
      if (s != 0 && m_pend[s] && !hits(s)) raw = 1;
    end
    waw = (RdD != 0) && m_pend[RdD] && !hits(int'(RdD));
    str = McOpD &&
          (m_cnt + int'(McIssueE) - int'(McDone) >= MAX_OUT);
    stall = lus | raw | waw | str;
    e.stf  = stall && !PCSrcE;
    e.std  = stall && !PCSrcE;
    e.fld  = PCSrcE;
    e.fle  = PCSrcE || stall;
    e.pend = m_pend;
    e.busy = (m_cnt == MAX_OUT);
    e.err  = m_err;
    e.sc   = CNT_W'(m_sc);
    return e;
  endfunction

  function automatic void model_step(input bit std);
    m_err = McDone &&
            (m_cnt == 0 || (McRd != 0 && !m_pend[McRd]));
    if (McDone) begin
      if (m_cnt > 0) m_cnt--;
      m_pend[McRd] = 1'b0;
    end
    if (McIssueE) begin
      m_cnt++;
      if (RdE != 0) m_pend[RdE] = 1'b1;
    end
    if (std && m_sc < SCMAX) m_sc++;
  endfunction

  // called at posedge+1 with inputs already applied
  task automatic tick();
    exp_t e;
    if (!reset_n) model_clear();
    e = model_out();
    q.push_back(e);
    model_step(e.std);
    if (!reset_n) model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RsD = '0; RsE = '0; RdD = '0; RdE = '0; RdM = '0; RdW = '0;
    McRd = '0; McOpD = 0; RegWriteM = 0; RegWriteW = 0;
    MemReadE = 0; McIssueE = 0; McDone = 0; PCSrcE = 0;
  endtask

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp("ForwardE",  32'(ForwardE), 32'(e.fwd));
      cmp("StallF",    32'(StallF),   32'(e.stf));
      cmp("StallD",    32'(StallD),   32'(e.std));
      cmp("FlushD",    32'(FlushD),   32'(e.fld));
      cmp("FlushE",    32'(FlushE),   32'(e.fle));
      cmp("McPending", McPending,     e.pend);
      cmp("McBusy",    32'(McBusy),   32'(e.busy));
      cmp("McErr",     32'(McErr),    32'(e.err));
      cmp("StallCnt",  32'(StallCnt), 32'(e.sc));
    end
  end

  task automatic rand_cycle();
    int pl[$];
    int nx0, r;
    bit dec;
    idle();
    for (int i = 0; i < NSRC; i++) begin
      RsD[i*AW +: AW] = AW'($urandom_range(0, 7));
      RsE[i*AW +: AW] = AW'($urandom_range(0, 7));
    end
    RdD = AW'($urandom_range(0, 7));
    RdM = AW'($urandom_range(0, 7));
    RdW = AW'($urandom_range(0, 7));
    RdE = AW'($urandom_range(0, 7));
    RegWriteM = 1'($urandom_range(0, 1));
    RegWriteW = 1'($urandom_range(0, 1));
    MemReadE  = ($urandom_range(0, 3) == 0);
    McOpD     = ($urandom_range(0, 2) == 0);
    PCSrcE    = ($urandom_range(0, 7) == 0);
    for (int k = 1; k < 32; k++) if (m_pend[k]) pl.push_back(k);
    nx0 = m_cnt - pl.size();
    if (m_cnt > 0 && $urandom_range(0, 2) == 0) begin
      McDone = 1;
      if (pl.size() > 0 && (nx0 == 0 || $urandom_range(0, 1) == 1))
        McRd = AW'(pl[$urandom_range(0, pl.size() - 1)]);
      else
        McRd = '0;
    end else if (m_cnt == 0 && $urandom_range(0, 19) == 0) begin
      McDone = 1;
      McRd = AW'($urandom_range(0, 7));
    end
    dec = McDone && m_cnt > 0;
    if (m_cnt - int'(dec) < MAX_OUT && $urandom_range(0, 2) == 0) begin
      McIssueE = 1;
      r = int'(RdE);
      if (r != 0 && m_pend[r] && !(dec && int'(McRd) == r)) RdE = '0;
    end
    tick();
  endtask

  initial begin
    idle();
    model_clear();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    tick();
    // forwarding priority
    RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1;
    RsE[0 +: AW] = 5;
    tick();
    RegWriteM = 0;
    tick();
    RsE[0 +: AW] = 0;
    tick();
    // load-use, then with a taken branch
    idle();
    MemReadE = 1; RdE = 7; RsD[AW +: AW] = 7;
    tick();
    idle();
    tick();
    MemReadE = 1; RdE = 7; RsD[AW +: AW] = 7; PCSrcE = 1;
    tick();
    idle();
    tick();
    // scoreboard RAW until completion
    McIssueE = 1; RdE = 9;
    tick();
    idle();
    RsD[0 +: AW] = 9;
    repeat (3) tick();
    McDone = 1; McRd = 9; RsE[AW +: AW] = 9;
    tick();
    idle();
    tick();
    // structural limit
    McIssueE = 1; RdE = 3;
    tick();
    RdE = 4;
    tick();
    idle();
    McOpD = 1;
    tick();
    McDone = 1; McRd = 3;
    tick();
    idle();
    McDone = 1; McRd = 4;
    tick();
    idle();
    tick();
    // same-cycle set and clear
    McIssueE = 1; RdE = 6;
    tick();
    McDone = 1; McRd = 6;
    tick();
    idle();
    tick();
    McDone = 1; McRd = 6;
    tick();
    idle();
    // asynchronous reset with ops in flight
    McIssueE = 1; RdE = 3;
    tick();
    RdE = 4;
    tick();
    idle();
    #2;
    reset_n = 0;
    tick();
    reset_n = 1;
    McDone = 1; McRd = 3;
    tick();
    idle();
    repeat (2) tick();
    // stall counter saturation
    MemReadE = 1; RdE = 2; RsD[0 +: AW] = 2;
    repeat (20) tick();
    idle();
    tick();
    // random traffic
    for (int n = 0; n < 600; n++) rand_cycle();
    idle();
    tick();
    @(negedge clk);
    #1;
    cmp("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
Parametrised hazard and forwarding unit for the 5-stage pipeline. It adds a register scoreboard for a multi-cycle execution unit (mul/div) that retires out of band. It generates per-operand forward selects, load-use and scoreboard stalls, branch flushes, and a saturating stall-cycle counter. It sits beside the datapath and drives the F/D/E pipeline-register enables and clears plus the E-stage operand muxes.

Parameters:
AW, 5, register address width; register file holds 2**AW entries, x0 hard-wired zero
NSRC, 2, source operands per instruction (D and E stage)
MAX_OUT, 2, maximum multi-cycle ops outstanding (1..2**AW-1)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
RsD  in  NSRC*AW  decode-stage source registers, operand i at [i*AW +: AW]
RdD  in  AW  decode-stage destination
McOpD  in  1  decode-stage instruction is a multi-cycle op
RsE  in  NSRC*AW  execute-stage source registers
RdE, RdM, RdW  in  AW each  destinations in E/M/W
RegWriteM, RegWriteW  in  1 each  normal-path register write in M/W
MemReadE  in  1  E-stage instruction is a load
McIssueE  in  1  E-stage instruction issues to the multi-cycle unit, dest RdE
McDone  in  1  multi-cycle unit writes McRd this cycle
McRd  in  AW  multi-cycle writeback register
PCSrcE  in  1  taken branch/jump resolved in E
ForwardE  out  NSRC*2  per-operand select: 00 regfile, 10 M, 01 W, 11 multi-cycle result bus
StallF, StallD  out  1 each  hold PC / IF-ID register
FlushD, FlushE  out  1 each  clear IF-ID / ID-EX register
McPending  out  2**AW  scoreboard vector, bit r = write to r outstanding
McBusy  out  1  outstanding count == MAX_OUT
McErr  out  1  one-cycle pulse: McDone with McRd not pending
StallCnt  out  CNT_W  cycles with StallD=1, saturating

Behaviour:
- Reset (async assert, sync release):
  - Scoreboard, outstanding count, StallCnt and McErr all 0.
  - All other outputs are combinational from state and inputs, so with idle inputs they reset to 0.
- Forwarding, per operand i, comparing src = RsE[i]. Registers equal to 0 never forward. Priority:
  - RegWriteM & RdM==src -> 10
  - else RegWriteW & RdW==src -> 01
  - else McDone & McRd==src -> 11
  - else 00
- Load/MC-use stall (lus): (MemReadE | McIssueE) & RdE!=0 & RdE equals any RsD[i].
- Scoreboard RAW (raw): any RsD[i]!=0 with McPending[RsD[i]] & !(McDone & McRd==RsD[i]). A register completing this cycle is readable through the regfile write-first path, so no stall.
- Scoreboard WAW (waw): RdD!=0 & McPending[RdD] & !(McDone & McRd==RdD).
- Structural stall (str): McOpD & (count + McIssueE - McDone) >= MAX_OUT.
- Stall generation:
  - stall = lus | raw | waw | str.
  - StallF = StallD = stall & !PCSrcE.
  - FlushD = PCSrcE.
  - FlushE = PCSrcE | stall.
- Scoreboard update, one cycle latency:
  - On McIssueE & RdE!=0, set bit RdE.
  - On McDone, clear bit McRd.
  - Same register set and cleared in one cycle: set wins.
  - Count += McIssueE (counted even when RdE==0) and -= McDone. The net change is 0 when both occur.
- Count boundaries:
  - Count never exceeds MAX_OUT; structural stall prevents issue past it.
  - Count never goes below 0: McDone at 0 is ignored and McErr pulses.
  - McErr also pulses when McRd!=0 and its bit is clear.
- McBusy = (count == MAX_OUT).
- StallCnt increments on each cycle with StallD=1 and holds at 2**CNT_W-1.
- Reset mid-operation drops all pending state. A later McDone for a lost op yields McErr and no state change.

Decomposition:
- Shared package hazard_pkg holds:
  - fwd_sel_e enum (FWD_RF=00, FWD_W=01, FWD_M=10, FWD_MC=11)
  - default AW
  - function reg_match(a, b) returning a==b && a!=0
- One sub-module, mc_scoreboard, owns the pending vector, outstanding counter and McErr. Its inputs are issue/done/reg and its outputs are McPending and count.
- Forwarding and stall logic stay in the top module as combinational blocks.

Test Plan:
1. Forwarding priority: RdM=RdW=5, both RegWrite=1, RsE[0]=5 -> ForwardE[1:0]=10. Then RegWriteM=0 -> 01. Then RsE[0]=0 with the same writes -> 00.
2. Load-use: MemReadE=1, RdE=7, RsD[1]=7 -> StallF=StallD=FlushE=1 for exactly 1 cycle, StallCnt 0->1. Then same case with PCSrcE=1 -> StallF=StallD=0, FlushD=FlushE=1.
3. Scoreboard RAW: McIssueE with RdE=9. Next cycle McPending[9]=1 and RsD[0]=9 -> stall held each cycle until McDone, McRd=9. The McDone cycle has stall=0 and bit 9 clears next cycle. An E operand reading 9 in that cycle -> ForwardE=11.
4. Structural (MAX_OUT=2): two issues to regs 3 and 4, then McOpD -> McBusy=1, stall=1. McDone for 3 in the same cycle as McOpD -> no stall.
5. Same-cycle set/clear: pending bit 6, McDone McRd=6 and McIssueE RdE=6 together -> bit 6 stays 1, count unchanged.
6. Reset mid-operation: two ops pending, pulse reset_n low asynchronously (mid-cycle) -> McPending=0 and count=0 immediately. Then McDone McRd=3 -> McErr=1 for one cycle, count stays 0.
7. StallCnt saturation with CNT_W=4: 20 consecutive stall cycles -> StallCnt=15.
